// File: rtl/llr_frame_loader_pkg.sv
// llr_frame_loader_pkg
//   Constants and types shared between the frame loader and the PE datapath.
//   LLR_P : LLR lanes per packed memory word (PE input lane count)
//   LLR_Q : quantized LLR width in bits (PE datapath width)
//   LLR_N : code length
//   ldr_state_e : frame loader FSM state encoding
package llr_frame_loader_pkg;

   localparam int LLR_P = 64;
   localparam int LLR_Q = 6;
   localparam int LLR_N = 1024;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,   // accepting samples
      ST_FLUSH = 2'd1,   // last word of a frame being written, input held off
      ST_STALL = 2'd2    // target bank still owned by the decoder
   } ldr_state_e;

endpackage

// File: rtl/llr_frame_loader_sat.sv
// llr_sat
//   Symmetric saturation of a two's complement channel LLR to Q bits.
//   Output range is [-(2^(Q-1)-1), +(2^(Q-1)-1)]; the most negative Q-bit
//   code is never produced so that negation in the PE cannot overflow.
//   llr_i : IW-bit signed input sample
//   llr_o : Q-bit signed saturated sample (combinational)
module llr_sat #(
   parameter int IW = 8,
   parameter int Q  = 6
) (
   input  logic signed [IW-1:0] llr_i,
   output logic        [Q-1:0]  llr_o
);

   localparam int                   SMAX_I = (1 << (Q - 1)) - 1;
   localparam logic signed [IW-1:0] SMAX   = SMAX_I[IW-1:0];
   localparam logic signed [IW-1:0] SMIN   = -SMAX;

   logic signed [IW-1:0] clip;

   always_comb begin
      clip = llr_i;
      if (llr_i > SMAX)      clip = SMAX;
      else if (llr_i < SMIN) clip = SMIN;
      // clip is now inside the Q-bit range, so truncation keeps the value
      llr_o = clip[Q-1:0];
   end

endmodule

// File: rtl/llr_frame_loader.sv
// llr_frame_loader
//   Collects a serial stream of channel LLRs, saturates them to Q bits, packs
//   P of them per word and writes N/P words per frame into one of two banks
//   of the PE LLR memory (ping-pong). A bank stays occupied until the decoder
//   releases it.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_llr/in_valid      : input sample stream; in_ready accepts it
//   wr_en/wr_addr/wr_data: memory write port, addr = {bank, word}
//   frame_rdy/frame_bank : one-cycle pulse when a bank has been filled
//   bank_full            : per-bank occupied flags
//   rel_en/rel_bank      : decoder releases a bank
//   Requires P >= 2 and W = N/P >= 2, W a power of two.
module llr_frame_loader
   import llr_frame_loader_pkg::*;
#(
   parameter int P  = LLR_P,
   parameter int Q  = LLR_Q,
   parameter int N  = LLR_N,
   parameter int IW = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [IW-1:0]    in_llr,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    wr_en,
   output logic [$clog2(N/P):0]    wr_addr,
   output logic [P*Q-1:0]          wr_data,
   output logic                    frame_rdy,
   output logic                    frame_bank,
   output logic [1:0]              bank_full,
   input  logic                    rel_en,
   input  logic                    rel_bank
);

   localparam int W  = N / P;
   localparam int WB = $clog2(W);
   localparam int LB = $clog2(P);
   localparam logic [WB-1:0] WORD_LAST = WB'(W - 1);
   localparam logic [LB-1:0] LANE_LAST = LB'(P - 1);

   ldr_state_e            state_q, state_d;
   logic                  wbank_q, wbank_d;
   logic [LB-1:0]         lane_q, lane_d;
   logic [WB-1:0]         word_q, word_d;
   logic [P-1:0][Q-1:0]   pk_q, pk_d;
   logic                  in_ready_q, in_ready_d;
   logic                  wr_en_q, wr_en_d;
   logic [WB:0]           wr_addr_q, wr_addr_d;
   logic                  frame_rdy_q, frame_rdy_d;
   logic                  frame_bank_q, frame_bank_d;
   logic [1:0]            bank_full_q, bank_full_d;

   logic [Q-1:0]          sat_llr;
   logic                  beat;
   logic                  last_lane;

   llr_sat #(.IW(IW), .Q(Q)) u_sat (
      .llr_i (in_llr),
      .llr_o (sat_llr)
   );

   assign beat      = in_valid && in_ready_q;
   assign last_lane = (lane_q == LANE_LAST);

   always_comb begin
      state_d      = state_q;
      wbank_d      = wbank_q;
      lane_d       = lane_q;
      word_d       = word_q;
      pk_d         = pk_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      frame_rdy_d  = 1'b0;
      frame_bank_d = frame_bank_q;
      bank_full_d  = bank_full_q;

      // Packing register doubles as write data: on the last lane the word is
      // complete at the edge and is presented together with wr_en next cycle.
      if (beat) begin
         pk_d[lane_q] = sat_llr;
         if (last_lane) begin
            lane_d    = '0;
            word_d    = word_q + 1'b1;   // W is a power of two: wraps naturally
            wr_en_d   = 1'b1;
            wr_addr_d = {wbank_q, word_q};
            if (word_q == WORD_LAST) begin
               frame_rdy_d  = 1'b1;
               frame_bank_d = wbank_q;
            end
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end

      // Release is applied first so a set in the same cycle (always on the
      // other bank) is never lost.
      if (rel_en) bank_full_d[rel_bank] = 1'b0;

      unique case (state_q)
         ST_FILL: begin
            if (beat && last_lane && (word_q == WORD_LAST)) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            bank_full_d[wbank_q] = 1'b1;
            wbank_d              = ~wbank_q;
            state_d              = bank_full_d[~wbank_q] ? ST_STALL : ST_FILL;
         end
         ST_STALL: begin
            if (!bank_full_d[wbank_q]) state_d = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase

      // Ready follows the next state, so a release of the stalled bank shows
      // up as in_ready exactly one cycle later.
      in_ready_d = (state_d == ST_FILL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_FILL;
         wbank_q      <= 1'b0;
         lane_q       <= '0;
         word_q       <= '0;
         pk_q         <= '0;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         frame_rdy_q  <= 1'b0;
         frame_bank_q <= 1'b0;
         bank_full_q  <= 2'b00;
      end else begin
         state_q      <= state_d;
         wbank_q      <= wbank_d;
         lane_q       <= lane_d;
         word_q       <= word_d;
         pk_q         <= pk_d;
         in_ready_q   <= in_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         frame_rdy_q  <= frame_rdy_d;
         frame_bank_q <= frame_bank_d;
         bank_full_q  <= bank_full_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = pk_q;
   assign frame_rdy  = frame_rdy_q;
   assign frame_bank = frame_bank_q;
   assign bank_full  = bank_full_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// tb_llr_frame_loader
//   Bench for llr_frame_loader with P=4, Q=6, N=8, IW=8 (two words per frame).
//   Expected memory writes are pushed to a scoreboard when a beat is accepted
//   and compared (cycle, address, data, frame pulse) when wr_en appears.
module tb_llr_frame_loader;

   localparam int P  = 4;
   localparam int Q  = 6;
   localparam int N  = 8;
   localparam int IW = 8;

   logic                 clk;
   logic                 rst_n;
   logic signed [IW-1:0] in_llr;
   logic                 in_valid;
   logic                 in_ready;
   logic                 wr_en;
   logic [1:0]           wr_addr;
   logic [P*Q-1:0]       wr_data;
   logic                 frame_rdy;
   logic                 frame_bank;
   logic [1:0]           bank_full;
   logic                 rel_en;
   logic                 rel_bank;

   llr_frame_loader #(.P(P), .Q(Q), .N(N), .IW(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_llr     (in_llr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_rdy  (frame_rdy),
      .frame_bank (frame_bank),
      .bank_full  (bank_full),
      .rel_en     (rel_en),
      .rel_bank   (rel_bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [1:0]      addr;
      logic [P*Q-1:0]  data;
      logic            fr;
      int              cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic signed [IW-1:0] in;
      logic signed [Q-1:0]  exp;
   } vec_t;
   vec_t tbl[8];

   // bench-side model of the loader write pointer
   int             mlane = 0;
   int             mword = 0;
   logic           mbank = 1'b0;
   logic [P*Q-1:0] mpk   = '0;

   task automatic chk(input string nm, input longint act, input longint req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic logic [Q-1:0] satm(input logic signed [IW-1:0] v);
      int x;
      x = v;
      if (x > 31)  x = 31;
      if (x < -31) x = -31;
      return x[Q-1:0];
   endfunction

   task automatic accept(input logic [Q-1:0] e);
      exp_t r;
      mpk[mlane*Q +: Q] = e;
      if (mlane == P - 1) begin
         r.addr = {mbank, mword[0]};
         r.data = mpk;
         r.fr   = (mword == N / P - 1);
         r.cyc  = cyc + 1;
         sb.push_back(r);
         mlane = 0;
         if (mword == N / P - 1) begin
            mword = 0;
            mbank = ~mbank;
         end else begin
            mword++;
         end
      end else begin
         mlane++;
      end
   endtask

   // Drives one sample and returns #1 after the edge that accepted it.
   task automatic beat(input logic signed [IW-1:0] v, input logic [Q-1:0] e);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_llr   = v;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            accept(e);
         end
      end
      if (!ok) chk("beat_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat();
      logic signed [IW-1:0] r;
      r = IW'($urandom);
      beat(r, satm(r));
   endtask

   // write monitor / scoreboard pop
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && wr_en) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            chk("frame_rdy", frame_rdy, e.fr);
            if (e.fr) chk("frame_bank", frame_bank, e.addr[1]);
         end
      end
      if (rst_n && frame_rdy && !wr_en) chk("frame_rdy_without_write", 1, 0);
   end

   initial begin
      tbl[0] = '{ 8'sd40,  6'sd31};
      tbl[1] = '{-8'sd40, -6'sd31};
      tbl[2] = '{-8'sd32, -6'sd31};
      tbl[3] = '{ 8'sd31,  6'sd31};
      tbl[4] = '{-8'sd31, -6'sd31};
      tbl[5] = '{ 8'sd0,   6'sd0};
      tbl[6] = '{-8'sd1,  -6'sd1};
      tbl[7] = '{-8'sd128, -6'sd31};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_llr   = '0;
      rel_en   = 1'b0;
      rel_bank = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_frame_rdy", frame_rdy, 0);
      chk("rst_frame_bank", frame_bank, 0);
      chk("rst_bank_full", bank_full, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // frame 1 -> bank 0: continuous beats 1..8
      for (int i = 1; i <= 8; i++) beat(IW'(i), Q'(i));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("bank_full_after_f1", bank_full, 2'b01);
      @(posedge clk);
      #1;

      // frame 2 -> bank 1: saturation table
      for (int i = 0; i < 8; i++) beat(tbl[i].in, tbl[i].exp);

      // both banks full: further input must stall
      in_llr = 8'sd9;
      repeat (3) @(negedge clk);
      chk("bank_full_both", bank_full, 2'b11);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rel_en   = 1'b1;
      rel_bank = 1'b0;
      @(negedge clk);
      chk("rel_cycle_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rel_en   = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rel_next_in_ready", in_ready, 1);
      chk("bank_full_after_rel", bank_full, 2'b10);
      @(posedge clk);
      #1;

      // frame 3 -> bank 0: random valid gaps; release bank 1 in the flush cycle
      for (int i = 1; i <= 8; i++) begin
         if (i > 1 && $urandom_range(1) == 1) gap();
         beat(IW'(i), Q'(i));
      end
      in_valid = 1'b0;
      rel_en   = 1'b1;
      rel_bank = 1'b1;
      @(posedge clk);
      #1;
      rel_en = 1'b0;
      @(negedge clk);
      chk("bank_full_set_rel_same", bank_full, 2'b01);
      chk("in_ready_after_set_rel", in_ready, 1);
      @(posedge clk);
      #1;

      // frame 4 -> bank 1, reset after 3 beats of word 1
      for (int i = 0; i < 7; i++) rand_beat();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_frame_rdy", frame_rdy, 0);
      chk("midrst_frame_bank", frame_bank, 0);
      chk("midrst_bank_full", bank_full, 0);
      chk("midrst_sb_empty", sb.size(), 0);
      mlane = 0;
      mword = 0;
      mbank = 1'b0;
      mpk   = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // frame 5 -> bank 0 from lane 0, word 0
      for (int i = 0; i < 8; i++) rand_beat();
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bank_full_after_f5", bank_full, 2'b01);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
